y86_dmem_ctrl: RTL and testbench

- Parametrised data-memory stage for the Y86 core, successor to the single-cycle combinational memory stage.
- Decodes icode into a read, a write or no access, and selects the address (valE or valA) and write data (valA or valP).
- Executes the access against a byte-addressed, little-endian array with a configurable latency and a start/done handshake, so the sequential and pipelined cores can stall on it.
- Reports per-access and sticky out-of-range errors.

---
 rtl/y86_pkg.sv | 34 +++
 rtl/y86_dmem_array.sv | 35 +++
 rtl/y86_dmem_ctrl.sv | 142 ++++++++++++++
 tb/tb_y86_dmem_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared constants and types for the Y86 data-memory stage.
// Holds the icode encodings, the access-kind enum, the FSM states and the decoder.
package y86_pkg;

   localparam logic [3:0] ICODE_RMMOVQ = 4'd4;
   localparam logic [3:0] ICODE_MRMOVQ = 4'd5;
   localparam logic [3:0] ICODE_CALL   = 4'd8;
   localparam logic [3:0] ICODE_RET    = 4'd9;
   localparam logic [3:0] ICODE_PUSHQ  = 4'd10;
   localparam logic [3:0] ICODE_POPQ   = 4'd11;

   typedef enum logic [1:0] {
      MEM_NONE,
      MEM_READ,
      MEM_WRITE
   } mem_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } dmem_state_t;

   function automatic mem_op_t decode_op(input logic [3:0] icode);
      mem_op_t op;
      case (icode)
         ICODE_MRMOVQ, ICODE_RET, ICODE_POPQ:    op = MEM_READ;
         ICODE_RMMOVQ, ICODE_PUSHQ, ICODE_CALL:  op = MEM_WRITE;
         default:                                op = MEM_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/y86_dmem_array.sv
// Byte-addressed little-endian storage: one synchronous NB-byte write port and
// one asynchronous NB-byte read port. Indices wrap; the controller gates range.
module y86_dmem_array #(
   parameter int    DEPTH_BYTES = 1024,
   parameter int    DATA_W      = 64,
   parameter string INIT_FILE   = "",
   localparam int   NB          = DATA_W / 8,
   localparam int   AW          = $clog2(DEPTH_BYTES)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [7:0] mem [DEPTH_BYTES];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            mem[waddr + AW'(i)] <= wdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NB; i++) begin
         rdata[8*i +: 8] = mem[raddr + AW'(i)];
      end
   end

endmodule

// File: rtl/y86_dmem_ctrl.sv
// Y86 data-memory stage: decodes icode, latches the request, waits LAT edges,
// then performs a range-checked access and pulses done for one cycle.
module y86_dmem_ctrl
   import y86_pkg::*;
#(
   parameter int    DEPTH_BYTES = 1024,
   parameter int    DATA_W      = 64,
   parameter int    ADDR_W      = 64,
   parameter int    LAT         = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        icode,
   input  logic [ADDR_W-1:0] valA,
   input  logic [ADDR_W-1:0] valE,
   input  logic [ADDR_W-1:0] valP,
   output logic              ready,
   output logic              done,
   output logic [DATA_W-1:0] valM,
   output logic              mem_error,
   output logic              mem_error_sticky,
   output logic [DATA_W-1:0] stored_in_mem
);

   localparam int NB    = DATA_W / 8;
   localparam int AW    = $clog2(DEPTH_BYTES);
   localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
   // Highest legal start byte; compared at full ADDR_W so large addresses never wrap in.
   localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH_BYTES - NB);

   dmem_state_t        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   mem_op_t            op_q, op_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [DATA_W-1:0]  valm_q, valm_d;
   logic               err_q, err_d;
   logic               sticky_q, sticky_d;
   logic [DATA_W-1:0]  stored_q, stored_d;

   logic               access_we;
   logic               addr_err;
   logic [DATA_W-1:0]  rdata;

   assign addr_err = (addr_q > MAX_ADDR);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      valm_d    = valm_q;
      err_d     = err_q;
      sticky_d  = sticky_q;
      stored_d  = stored_q;
      access_we = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d    = decode_op(icode);
               addr_d  = (icode == ICODE_RET || icode == ICODE_POPQ) ? valA : valE;
               wdata_d = (icode == ICODE_CALL) ? DATA_W'(valP) : DATA_W'(valA);
               cnt_d   = CNT_W'(LAT - 1);
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = ST_DONE;
               case (op_q)
                  MEM_READ: begin
                     err_d    = addr_err;
                     sticky_d = sticky_q | addr_err;
                     valm_d   = addr_err ? '0 : rdata;
                     stored_d = addr_err ? '0 : rdata;
                  end
                  MEM_WRITE: begin
                     err_d     = addr_err;
                     sticky_d  = sticky_q | addr_err;
                     access_we = ~addr_err;
                     stored_d  = addr_err ? '0 : wdata_q;
                  end
                  default: err_d = 1'b0;
               endcase
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= MEM_NONE;
         addr_q   <= '0;
         wdata_q  <= '0;
         valm_q   <= '0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
         stored_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         valm_q   <= valm_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
         stored_q <= stored_d;
      end
   end

   // A reset landing on the access edge must drop the pending write.
   y86_dmem_array #(
      .DEPTH_BYTES (DEPTH_BYTES),
      .DATA_W      (DATA_W),
      .INIT_FILE   (INIT_FILE)
   ) u_array (
      .clk   (clk),
      .we    (access_we & ~rst),
      .waddr (addr_q[AW-1:0]),
      .wdata (wdata_q),
      .raddr (addr_q[AW-1:0]),
      .rdata (rdata)
   );

   assign ready            = (state_q == ST_IDLE);
   assign done             = (state_q == ST_DONE);
   assign valM             = valm_q;
   assign mem_error        = err_q;
   assign mem_error_sticky = sticky_q;
   assign stored_in_mem    = stored_q;

endmodule

// File: tb/tb_y86_dmem_ctrl.sv
// Directed bench for y86_dmem_ctrl: three instances at LAT=1, 3 and 4 share
// clock and reset; each vector carries hand-computed expected values.
module tb_y86_dmem_ctrl;

   localparam int LAT0 = 1;
   localparam int LAT1 = 3;
   localparam int LAT2 = 4;

   logic        clk;
   logic        rst;
   logic        start  [3];
   logic [3:0]  icode  [3];
   logic [63:0] va     [3];
   logic [63:0] ve     [3];
   logic [63:0] vp     [3];
   logic        ready  [3];
   logic        done   [3];
   logic [63:0] valm   [3];
   logic        merr   [3];
   logic        msticky[3];
   logic [63:0] stored [3];

   int n_tests;
   int n_fail;
   int last_cyc;
   int last_rdy_low;
   int lat_of [3];

   y86_dmem_ctrl #(.DEPTH_BYTES(1024), .DATA_W(64), .ADDR_W(64), .LAT(LAT0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .icode(icode[0]), .valA(va[0]), .valE(ve[0]),
      .valP(vp[0]), .ready(ready[0]), .done(done[0]), .valM(valm[0]), .mem_error(merr[0]),
      .mem_error_sticky(msticky[0]), .stored_in_mem(stored[0]));

   y86_dmem_ctrl #(.DEPTH_BYTES(1024), .DATA_W(64), .ADDR_W(64), .LAT(LAT1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .icode(icode[1]), .valA(va[1]), .valE(ve[1]),
      .valP(vp[1]), .ready(ready[1]), .done(done[1]), .valM(valm[1]), .mem_error(merr[1]),
      .mem_error_sticky(msticky[1]), .stored_in_mem(stored[1]));

   y86_dmem_ctrl #(.DEPTH_BYTES(1024), .DATA_W(64), .ADDR_W(64), .LAT(LAT2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start[2]), .icode(icode[2]), .valA(va[2]), .valE(ve[2]),
      .valP(vp[2]), .ready(ready[2]), .done(done[2]), .valM(valm[2]), .mem_error(merr[2]),
      .mem_error_sticky(msticky[2]), .stored_in_mem(stored[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive a request in an IDLE cycle; returns just after the accepting edge.
   task automatic begin_op(input int k, input logic [3:0] ic, input logic [63:0] a,
                           input logic [63:0] e, input logic [63:0] p);
      @(negedge clk);
      check("ready_before_start", {63'd0, ready[k]}, 64'd1);
      start[k] = 1'b1;
      icode[k] = ic;
      va[k]    = a;
      ve[k]    = e;
      vp[k]    = p;
      @(posedge clk);
      #1;
      start[k] = 1'b0;
      icode[k] = 4'hF;
      va[k]    = 64'hDEAD_BEEF_DEAD_BEEF;
      ve[k]    = 64'hDEAD_BEEF_DEAD_BEEF;
      vp[k]    = 64'hDEAD_BEEF_DEAD_BEEF;
   endtask

   task automatic wait_done(input int k);
      last_cyc     = 0;
      last_rdy_low = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         last_cyc++;
         if (!ready[k]) last_rdy_low++;
         if (done[k]) break;
      end
      check("done_seen", {63'd0, done[k]}, 64'd1);
      check("latency", 64'(last_cyc), 64'(lat_of[k] + 1));
   endtask

   task automatic op(input int k, input logic [3:0] ic, input logic [63:0] a,
                     input logic [63:0] e, input logic [63:0] p);
      begin_op(k, ic, a, e, p);
      wait_done(k);
   endtask

   initial begin
      int acc;
      int dn;
      n_tests   = 0;
      n_fail    = 0;
      lat_of[0] = LAT0;
      lat_of[1] = LAT1;
      lat_of[2] = LAT2;
      for (int k = 0; k < 3; k++) begin
         start[k] = 1'b0;
         icode[k] = 4'h0;
         va[k]    = '0;
         ve[k]    = '0;
         vp[k]    = '0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready",  {63'd0, ready[0]},   64'd1);
      check("rst_done",   {63'd0, done[0]},    64'd0);
      check("rst_valm",   valm[0],             64'd0);
      check("rst_err",    {63'd0, merr[0]},    64'd0);
      check("rst_sticky", {63'd0, msticky[0]}, 64'd0);
      check("rst_stored", stored[0],           64'd0);

      // Write then read back a full word.
      op(0, 4'd4, 64'h1122334455667788, 64'd16, 64'd0);
      check("wr16_stored", stored[0], 64'h1122334455667788);
      check("wr16_err",    {63'd0, merr[0]}, 64'd0);
      op(0, 4'd5, 64'd0, 64'd16, 64'd0);
      check("rd16_valm",   valm[0],   64'h1122334455667788);
      check("rd16_stored", stored[0], 64'h1122334455667788);
      check("rd16_byte0",  valm[0] & 64'hFF, 64'h88);

      // Last legal word, then one byte past it.
      op(0, 4'd4, 64'hCAFE, 64'd1016, 64'd0);
      op(0, 4'd5, 64'd0, 64'd1016, 64'd0);
      check("rd1016_valm",   valm[0], 64'hCAFE);
      check("rd1016_err",    {63'd0, merr[0]},    64'd0);
      check("rd1016_sticky", {63'd0, msticky[0]}, 64'd0);
      op(0, 4'd5, 64'd0, 64'd1017, 64'd0);
      check("rd1017_err",    {63'd0, merr[0]},    64'd1);
      check("rd1017_valm",   valm[0],             64'd0);
      check("rd1017_sticky", {63'd0, msticky[0]}, 64'd1);
      check("rd1017_stored", stored[0],           64'd0);

      // 2000 mod 1024 = 976: an out-of-range write must not alias there.
      op(0, 4'd4, 64'h3C3C, 64'd976, 64'd0);
      op(0, 4'd10, 64'hDEAD, 64'd2000, 64'd0);
      check("push2000_err",    {63'd0, merr[0]}, 64'd1);
      check("push2000_stored", stored[0],        64'd0);
      op(0, 4'd5, 64'd0, 64'd976, 64'd0);
      check("rd976_valm",   valm[0],             64'h3C3C);
      check("rd976_err",    {63'd0, merr[0]},    64'd0);
      check("rd976_sticky", {63'd0, msticky[0]}, 64'd1);

      op(0, 4'd6, 64'h5555, 64'd24, 64'h7777);
      check("nop_valm",   valm[0],          64'h3C3C);
      check("nop_stored", stored[0],        64'h3C3C);
      check("nop_err",    {63'd0, merr[0]}, 64'd0);
      op(0, 4'd10, 64'hDEAD, 64'd2000, 64'd0);
      op(0, 4'd6, 64'd0, 64'd0, 64'd0);
      check("nop_clr_err",    {63'd0, merr[0]},    64'd0);
      check("nop_clr_sticky", {63'd0, msticky[0]}, 64'd1);
      op(0, 4'd5, 64'd0, 64'h0000_0001_0000_0010, 64'd0);
      check("rdhigh_err",  {63'd0, merr[0]}, 64'd1);
      check("rdhigh_valm", valm[0],          64'd0);

      // LAT=3: unaligned call write over a zeroed region.
      op(1, 4'd4, 64'd0, 64'd0, 64'd0);
      op(1, 4'd8, 64'h99, 64'd5, 64'hAB);
      check("call_rdy_low", 64'(last_rdy_low), 64'd4);
      check("call_stored",  stored[1], 64'hAB);
      op(1, 4'd11, 64'd5, 64'd999, 64'd0);
      check("pop5_valm", valm[1], 64'hAB);
      op(1, 4'd5, 64'd5, 64'd4, 64'd0);
      check("rd4_valm", valm[1], 64'hAB00);

      // LAT=4: reset on the 2nd busy edge drops the write.
      op(2, 4'd4, 64'h5A5A, 64'd32, 64'd0);
      begin_op(2, 4'd4, 64'hFF, 64'd32, 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_ready",  {63'd0, ready[2]},   64'd1);
      check("abort_done",   {63'd0, done[2]},    64'd0);
      check("abort_valm",   valm[2],             64'd0);
      check("abort_err",    {63'd0, merr[2]},    64'd0);
      check("abort_sticky", {63'd0, msticky[2]}, 64'd0);
      check("abort_stored", stored[2],           64'd0);
      check("abort_sticky0", {63'd0, msticky[0]}, 64'd0);
      op(2, 4'd5, 64'd0, 64'd32, 64'd0);
      check("abort_rd32", valm[2], 64'h5A5A);

      // LAT=1: reset coinciding with the access edge.
      op(0, 4'd4, 64'h77, 64'd40, 64'd0);
      begin_op(0, 4'd4, 64'hEE, 64'd40, 64'd0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      op(0, 4'd5, 64'd0, 64'd40, 64'd0);
      check("coinc_rd40", valm[0], 64'h77);

      // start held for five edges: only IDLE cycles accept.
      acc = 0;
      dn  = 0;
      @(negedge clk);
      start[0] = 1'b1;
      icode[0] = 4'd5;
      ve[0]    = 64'd40;
      for (int i = 0; i < 5; i++) begin
         if (ready[0]) acc++;
         if (done[0]) dn++;
         @(negedge clk);
      end
      start[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (done[0]) dn++;
         @(negedge clk);
      end
      check("hs_accepts", 64'(acc), 64'd2);
      check("hs_dones",   64'(dn),  64'd2);
      check("hs_valm",    valm[0],  64'h77);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
